wb_port_arbiter: RTL and testbench

Write-side companion to the register file: it owns the single register-file write port (`we`/`rd`/`wdata`) and merges two result producers into it. The in-order pipeline writeback always wins. Results from the multi-cycle mul/div unit are buffered in a small queue and drained on free cycles. Per-register pending flags let the ID stage stall on not-yet-written mul/div destinations.

---
 rtl/pipe_pkg.sv | 15 +
 rtl/wb_queue.sv | 77 +++++++
 rtl/wb_port_arbiter.sv | 92 +++++++++
 tb/tb_wb_port_arbiter.sv | 226 ++++++++++++++++++++++
 4 files changed

// File: rtl/pipe_pkg.sv
// Shared writeback types: register-file geometry and the queued result entry.
package pipe_pkg;

  localparam int REG_ADDR_W = 5;
  localparam int REG_D_W    = 32;

  localparam logic [REG_ADDR_W-1:0] REG_ZERO = '0;

  typedef struct packed {
    logic                  valid;
    logic [REG_ADDR_W-1:0] rd;
    logic [REG_D_W-1:0]    wdata;
  } wb_entry_t;

endpackage

// File: rtl/wb_queue.sv
// Circular FIFO of mul/div results with squash-by-rd and two rd-match lookups.
module wb_queue
  import pipe_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  push,
  input  wb_entry_t             push_entry,
  input  logic                  pop,
  input  logic                  squash_en,
  input  logic [REG_ADDR_W-1:0] squash_rd,
  input  logic [REG_ADDR_W-1:0] lookup_a_rd,
  input  logic [REG_ADDR_W-1:0] lookup_b_rd,
  output logic                  lookup_a_hit,
  output logic                  lookup_b_hit,
  output wb_entry_t             head,
  output logic                  empty,
  output logic                  full
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  wb_entry_t        mem [DEPTH];
  logic [PW-1:0]    rd_ptr;
  logic [PW-1:0]    wr_ptr;
  logic [CW-1:0]    cnt;

  // Popped slots are invalidated so unoccupied slots never produce lookup hits.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      cnt    <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else begin
      if (squash_en) begin
        for (int i = 0; i < DEPTH; i++) begin
          if (mem[i].rd == squash_rd) begin
            mem[i].valid <= 1'b0;
          end
        end
      end
      if (pop) begin
        mem[rd_ptr].valid <= 1'b0;
        rd_ptr            <= rd_ptr + PW'(1);
      end
      if (push) begin
        mem[wr_ptr] <= push_entry;
        wr_ptr      <= wr_ptr + PW'(1);
      end
      case ({push, pop})
        2'b10:   cnt <= cnt + CW'(1);
        2'b01:   cnt <= cnt - CW'(1);
        default: cnt <= cnt;
      endcase
    end
  end

  always_comb begin
    lookup_a_hit = 1'b0;
    lookup_b_hit = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      if (mem[i].valid && (mem[i].rd == lookup_a_rd)) lookup_a_hit = 1'b1;
      if (mem[i].valid && (mem[i].rd == lookup_b_rd)) lookup_b_hit = 1'b1;
    end
  end

  assign head  = mem[rd_ptr];
  assign empty = (cnt == '0);
  assign full  = (cnt == CW'(DEPTH));

endmodule

// File: rtl/wb_port_arbiter.sv
// Owns the register-file write port: pipeline writeback first, queued mul/div
// results on free cycles, plus per-source pending flags for the ID stage.
module wb_port_arbiter
  import pipe_pkg::*;
#(
  parameter int ADDR_WIDTH = REG_ADDR_W,
  parameter int D_WIDTH    = REG_D_W,
  parameter int Q_DEPTH    = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  pipe_we,
  input  logic [ADDR_WIDTH-1:0] pipe_rd,
  input  logic [D_WIDTH-1:0]    pipe_wdata,
  input  logic                  md_valid,
  input  logic [ADDR_WIDTH-1:0] md_rd,
  input  logic [D_WIDTH-1:0]    md_wdata,
  output logic                  md_ready,
  output logic                  rf_we,
  output logic [ADDR_WIDTH-1:0] rf_rd,
  output logic [D_WIDTH-1:0]    rf_wdata,
  input  logic [ADDR_WIDTH-1:0] chk_rs,
  input  logic [ADDR_WIDTH-1:0] chk_rt,
  output logic                  pend_rs,
  output logic                  pend_rt
);

  logic      pipe_req;
  logic      q_push;
  logic      q_pop;
  logic      q_empty;
  logic      q_full;
  logic      hit_rs;
  logic      hit_rt;
  wb_entry_t push_entry;
  wb_entry_t head;

  assign pipe_req = pipe_we && (pipe_rd != REG_ZERO);
  assign md_ready = !reset && !q_full;
  assign q_push   = md_valid && md_ready && (md_rd != REG_ZERO);
  assign q_pop    = !pipe_req && !q_empty;

  // A result arriving alongside a younger pipe write to the same rd is already dead.
  always_comb begin
    push_entry       = '0;
    push_entry.valid = !(pipe_req && (md_rd == pipe_rd));
    push_entry.rd    = md_rd;
    push_entry.wdata = md_wdata;
  end

  wb_queue #(
    .DEPTH(Q_DEPTH)
  ) u_queue (
    .clk         (clk),
    .reset       (reset),
    .push        (q_push),
    .push_entry  (push_entry),
    .pop         (q_pop),
    .squash_en   (pipe_req),
    .squash_rd   (pipe_rd),
    .lookup_a_rd (chk_rs),
    .lookup_b_rd (chk_rt),
    .lookup_a_hit(hit_rs),
    .lookup_b_hit(hit_rt),
    .head        (head),
    .empty       (q_empty),
    .full        (q_full)
  );

  // Address and data hold on idle cycles; only the enable drops.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rf_we    <= 1'b0;
      rf_rd    <= '0;
      rf_wdata <= '0;
    end else if (pipe_req) begin
      rf_we    <= 1'b1;
      rf_rd    <= pipe_rd;
      rf_wdata <= pipe_wdata;
    end else if (q_pop && head.valid) begin
      rf_we    <= 1'b1;
      rf_rd    <= head.rd;
      rf_wdata <= head.wdata;
    end else begin
      rf_we    <= 1'b0;
    end
  end

  assign pend_rs = (chk_rs != REG_ZERO) && (hit_rs || (rf_we && (rf_rd == chk_rs)));
  assign pend_rt = (chk_rt != REG_ZERO) && (hit_rt || (rf_we && (rf_rd == chk_rt)));

endmodule

// File: tb/tb_wb_port_arbiter.sv
// Self-checking bench: queue-based behavioural model, directed scenarios, random traffic.
module tb_wb_port_arbiter;

  localparam int AW = 5;
  localparam int DW = 32;
  localparam int QD = 4;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          pipe_we = 1'b0;
  logic [AW-1:0] pipe_rd = '0;
  logic [DW-1:0] pipe_wdata = '0;
  logic          md_valid = 1'b0;
  logic [AW-1:0] md_rd = '0;
  logic [DW-1:0] md_wdata = '0;
  logic          md_ready;
  logic          rf_we;
  logic [AW-1:0] rf_rd;
  logic [DW-1:0] rf_wdata;
  logic [AW-1:0] chk_rs = '0;
  logic [AW-1:0] chk_rt = '0;
  logic          pend_rs;
  logic          pend_rt;

  int checks = 0;
  int errors = 0;
  bit cmp_en = 1'b0;

  wb_port_arbiter #(
    .ADDR_WIDTH(AW),
    .D_WIDTH   (DW),
    .Q_DEPTH   (QD)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .pipe_we   (pipe_we),
    .pipe_rd   (pipe_rd),
    .pipe_wdata(pipe_wdata),
    .md_valid  (md_valid),
    .md_rd     (md_rd),
    .md_wdata  (md_wdata),
    .md_ready  (md_ready),
    .rf_we     (rf_we),
    .rf_rd     (rf_rd),
    .rf_wdata  (rf_wdata),
    .chk_rs    (chk_rs),
    .chk_rt    (chk_rt),
    .pend_rs   (pend_rs),
    .pend_rt   (pend_rt)
  );

  always #5 clk = ~clk;

  // Model: list of outstanding mul/div results plus the last port write.
  typedef struct {
    bit          valid;
    bit [AW-1:0] rd;
    bit [DW-1:0] data;
  } m_entry_t;

  m_entry_t    mq[$];
  bit          m_we = 1'b0;
  bit [AW-1:0] m_rd = '0;
  bit [DW-1:0] m_wdata = '0;

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      mq.delete();
      m_we    = 1'b0;
      m_rd    = '0;
      m_wdata = '0;
    end else begin
      bit       preq;
      bit       accept;
      m_entry_t e;
      preq   = pipe_we && (pipe_rd != 0);
      accept = md_valid && (mq.size() < QD);
      if (preq) begin
        foreach (mq[i]) if (mq[i].rd == pipe_rd) mq[i].valid = 1'b0;
        m_we = 1'b1; m_rd = pipe_rd; m_wdata = pipe_wdata;
      end else if (mq.size() > 0) begin
        e = mq.pop_front();
        m_we = e.valid;
        if (e.valid) begin m_rd = e.rd; m_wdata = e.data; end
      end else begin
        m_we = 1'b0;
      end
      if (accept && (md_rd != 0)) begin
        e.valid = !(preq && (md_rd == pipe_rd));
        e.rd    = md_rd;
        e.data  = md_wdata;
        mq.push_back(e);
      end
    end
  end

  function automatic bit m_pend(input bit [AW-1:0] a);
    if (a == 0) return 1'b0;
    if (m_we && (m_rd == a)) return 1'b1;
    foreach (mq[i]) if (mq[i].valid && (mq[i].rd == a)) return 1'b1;
    return 1'b0;
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s actual=0x%0h expected=0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (cmp_en) begin
      checkOutput("model rf_we", 32'(rf_we), 32'(m_we));
      checkOutput("model rf_rd", 32'(rf_rd), 32'(m_rd));
      checkOutput("model rf_wdata", rf_wdata, m_wdata);
      checkOutput("model md_ready", 32'(md_ready), 32'(!reset && (mq.size() < QD)));
      checkOutput("model pend_rs", 32'(pend_rs), 32'(m_pend(chk_rs)));
      checkOutput("model pend_rt", 32'(pend_rt), 32'(m_pend(chk_rt)));
    end
  end

  task automatic applyStimulus(input bit pwe, input bit [AW-1:0] prd, input bit [DW-1:0] pdata,
                               input bit mv, input bit [AW-1:0] mrd, input bit [DW-1:0] mdata,
                               input bit [AW-1:0] crs, input bit [AW-1:0] crt);
    pipe_we = pwe; pipe_rd = prd; pipe_wdata = pdata;
    md_valid = mv; md_rd = mrd; md_wdata = mdata;
    chk_rs = crs; chk_rt = crt;
    @(posedge clk);
    #1;
  endtask

  initial begin
    cmp_en = 1'b1;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    chk_rs = 5'd5;
    #1;
    checkOutput("idle rf_we", 32'(rf_we), 32'd0);
    checkOutput("idle md_ready", 32'(md_ready), 32'd1);
    checkOutput("idle pend_rs", 32'(pend_rs), 32'd0);

    // Single pipe write, visible for one cycle, address/data held afterwards.
    applyStimulus(1, 5'd5, 32'h11, 0, 0, 0, 5'd5, 5'd0);
    checkOutput("pipe rf_we", 32'(rf_we), 32'd1);
    checkOutput("pipe rf_rd", 32'(rf_rd), 32'd5);
    checkOutput("pipe rf_wdata", rf_wdata, 32'h11);
    checkOutput("pipe pend_rs", 32'(pend_rs), 32'd1);
    applyStimulus(0, 0, 0, 0, 0, 0, 5'd5, 5'd0);
    checkOutput("pipe done rf_we", 32'(rf_we), 32'd0);
    checkOutput("pipe hold rf_rd", 32'(rf_rd), 32'd5);

    // Fill the queue under a pipe stream, then drain in order.
    for (int i = 1; i <= 4; i++) begin
      applyStimulus(1, 5'd10, 32'h1000 + 32'(i), 1, 5'(i), 32'h100 + 32'(i), 5'd3, 5'd0);
    end
    checkOutput("full md_ready", 32'(md_ready), 32'd0);
    checkOutput("full pend_rs3", 32'(pend_rs), 32'd1);
    for (int i = 1; i <= 4; i++) begin
      applyStimulus(0, 0, 0, 0, 0, 0, 5'd3, 5'd0);
      checkOutput("drain rf_we", 32'(rf_we), 32'd1);
      checkOutput("drain rf_rd", 32'(rf_rd), 32'(i));
      checkOutput("drain rf_wdata", rf_wdata, 32'h100 + 32'(i));
    end
    checkOutput("drained md_ready", 32'(md_ready), 32'd1);
    checkOutput("drained pend_rs3", 32'(pend_rs), 32'd0);

    // Queued r7 result is squashed by a younger pipe write to r7.
    applyStimulus(1, 5'd9, 32'h99, 1, 5'd7, 32'hAA, 5'd7, 5'd0);
    checkOutput("squash queued pend", 32'(pend_rs), 32'd1);
    applyStimulus(1, 5'd7, 32'hBB, 0, 0, 0, 5'd7, 5'd0);
    checkOutput("squash rf_rd", 32'(rf_rd), 32'd7);
    checkOutput("squash rf_wdata", rf_wdata, 32'hBB);
    applyStimulus(0, 0, 0, 0, 0, 0, 5'd7, 5'd0);
    checkOutput("squashed pop rf_we", 32'(rf_we), 32'd0);
    checkOutput("squashed pend_rs", 32'(pend_rs), 32'd0);
    applyStimulus(0, 0, 0, 0, 0, 0, 5'd7, 5'd0);
    checkOutput("after squash rf_we", 32'(rf_we), 32'd0);

    // Register zero: mul/div handshake discarded, pipe write ignored.
    checkOutput("r0 md_ready", 32'(md_ready), 32'd1);
    applyStimulus(0, 0, 0, 1, 5'd0, 32'h55, 5'd0, 5'd0);
    checkOutput("r0 md rf_we", 32'(rf_we), 32'd0);
    applyStimulus(0, 0, 0, 0, 0, 0, 5'd0, 5'd0);
    checkOutput("r0 md no pop", 32'(rf_we), 32'd0);
    applyStimulus(1, 5'd0, 32'h66, 0, 0, 0, 5'd0, 5'd0);
    checkOutput("r0 pipe rf_we", 32'(rf_we), 32'd0);

    // Reset with three results queued and a write on the port.
    for (int i = 0; i < 3; i++) begin
      applyStimulus(1, 5'd11, 32'h77, 1, 5'd12 + 5'(i), 32'h200 + 32'(i), 5'd12, 5'd13);
    end
    pipe_we = 1'b0; md_valid = 1'b0;
    reset = 1'b1;
    #1;
    checkOutput("reset rf_we", 32'(rf_we), 32'd0);
    checkOutput("reset md_ready", 32'(md_ready), 32'd0);
    checkOutput("reset pend_rs", 32'(pend_rs), 32'd0);
    @(posedge clk);
    #1 reset = 1'b0;
    for (int i = 0; i < 3; i++) begin
      applyStimulus(0, 0, 0, 0, 0, 0, 5'd12, 5'd13);
      checkOutput("post reset rf_we", 32'(rf_we), 32'd0);
    end

    // Random traffic over a small register range to provoke squashes and stalls.
    for (int n = 0; n < 3000; n++) begin
      if ($urandom_range(199) == 0) begin
        pipe_we = 1'b0; md_valid = 1'b0;
        reset = 1'b1;
        @(posedge clk);
        #1 reset = 1'b0;
      end else begin
        applyStimulus($urandom_range(2) == 0, 5'($urandom_range(7)), $urandom,
                      $urandom_range(1) == 1, 5'($urandom_range(7)), $urandom,
                      5'($urandom_range(7)), 5'($urandom_range(7)));
      end
    end

    @(posedge clk);
    #1 cmp_en = 1'b0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
